// File: rtl/rotary_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_emulator
//  Purpose  : Emulates a front-panel rotary encoder (quadrature A/B plus push
//             button C) from a command port, so the frequency-select decoder
//             can be driven without a physical encoder. Idle is A=B=1; an
//             increment detent makes B fall first, a decrement makes A fall
//             first.
//  Ports    : Fg_clk     - system clock
//             Reset      - synchronous, active-high reset
//             Cmd_valid  - command request
//             Cmd_ready  - high only while idle
//             Cmd_dir    - 1 = increment (B leads), 0 = decrement (A leads)
//             Cmd_count  - number of detents to emit (0 allowed)
//             Cmd_press  - emit one button press instead of detents
//             Rot_A/B/C  - registered encoder outputs
//             Busy       - high while a command is executing
//             Done       - one-cycle pulse on return to idle
//             Remaining  - detents still to start, including the current one
//  Revision : 1.0 - initial release
// ============================================================================
module rotary_emulator #(
    parameter int PHASE_CYC = 16,
    parameter int GAP_CYC   = 32,
    parameter int CNT_W     = 8
) (
    input  logic             Fg_clk,
    input  logic             Reset,
    input  logic             Cmd_valid,
    output logic             Cmd_ready,
    input  logic             Cmd_dir,
    input  logic [CNT_W-1:0] Cmd_count,
    input  logic             Cmd_press,
    output logic             Rot_A,
    output logic             Rot_B,
    output logic             Rot_C,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Remaining
);

    localparam int MAX_CYC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] PHASE_LOAD = TMR_W'(PHASE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PH0   = 3'd1;
    localparam logic [2:0] PH1   = 3'd2;
    localparam logic [2:0] PH2   = 3'd3;
    localparam logic [2:0] PH3   = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;
    localparam logic [2:0] PRESS = 3'd6;

    logic [2:0]       state, next_state;
    logic [TMR_W-1:0] timer, next_timer;
    logic [CNT_W-1:0] next_rem;
    logic             dir, next_dir;
    logic             next_done;
    logic             next_a, next_b;
    logic             inc_a, inc_b;

    // Next-state logic. The timer counts down from (hold length - 1); a
    // phase ends on the cycle the timer reads zero.
    always_comb begin
        next_state = state;
        next_timer = timer;
        next_rem   = Remaining;
        next_dir   = dir;
        next_done  = 1'b0;
        case (state)
            IDLE: begin
                if (Cmd_valid) begin
                    next_dir = Cmd_dir;
                    if (Cmd_press) begin
                        next_state = PRESS;
                        next_rem   = '0;
                    end else if (Cmd_count == '0) begin
                        next_rem  = '0;
                        next_done = 1'b1;
                    end else begin
                        next_state = PH0;
                        next_timer = PHASE_LOAD;
                        next_rem   = Cmd_count;
                    end
                end
            end
            PH0, PH1, PH2: begin
                if (timer == '0) begin
                    next_state = state + 3'd1;
                    next_timer = PHASE_LOAD;
                end else begin
                    next_timer = timer - TMR_W'(1);
                end
            end
            PH3: begin
                if (timer == '0) begin
                    next_state = GAP;
                    next_timer = GAP_LOAD;
                    next_rem   = Remaining - CNT_W'(1);
                end else begin
                    next_timer = timer - TMR_W'(1);
                end
            end
            GAP: begin
                if (timer == '0) begin
                    if (Remaining != '0) begin
                        next_state = PH0;
                        next_timer = PHASE_LOAD;
                    end else begin
                        next_state = IDLE;
                        next_done  = 1'b1;
                    end
                end else begin
                    next_timer = timer - TMR_W'(1);
                end
            end
            PRESS: begin
                // Button is high for exactly one cycle, then the idle gap.
                next_state = GAP;
                next_timer = GAP_LOAD;
            end
            default: begin
                next_state = IDLE;
                next_timer = '0;
            end
        endcase
    end

    // Quadrature pattern for the upcoming state, increment orientation.
    // Decrement simply swaps A and B.
    always_comb begin
        inc_a = 1'b1;
        inc_b = 1'b1;
        case (next_state)
            PH0:     begin inc_a = 1'b1; inc_b = 1'b0; end
            PH1:     begin inc_a = 1'b0; inc_b = 1'b0; end
            PH2:     begin inc_a = 1'b0; inc_b = 1'b1; end
            default: begin inc_a = 1'b1; inc_b = 1'b1; end
        endcase
        next_a = next_dir ? inc_a : inc_b;
        next_b = next_dir ? inc_b : inc_a;
    end

    // Every output is a flop loaded from the next-state decode, so the
    // pins are glitch-free and change on the same edge as the state.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            state     <= IDLE;
            timer     <= '0;
            dir       <= 1'b0;
            Remaining <= '0;
            Rot_A     <= 1'b1;
            Rot_B     <= 1'b1;
            Rot_C     <= 1'b0;
            Busy      <= 1'b0;
            Cmd_ready <= 1'b1;
            Done      <= 1'b0;
        end else begin
            state     <= next_state;
            timer     <= next_timer;
            dir       <= next_dir;
            Remaining <= next_rem;
            Rot_A     <= next_a;
            Rot_B     <= next_b;
            Rot_C     <= (next_state == PRESS);
            Busy      <= (next_state != IDLE);
            Cmd_ready <= (next_state == IDLE);
            Done      <= next_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rotary_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotary_emulator
//  Purpose  : Directed self-checking bench for rotary_emulator with
//             PHASE_CYC=4, GAP_CYC=8, CNT_W=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rotary_emulator;

    localparam int PH  = 4;
    localparam int GP  = 8;
    localparam int DET = 4 * PH + GP;   // cycles per detent

    logic       Fg_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Cmd_valid = 1'b0;
    logic       Cmd_ready;
    logic       Cmd_dir = 1'b0;
    logic [7:0] Cmd_count = 8'd0;
    logic       Cmd_press = 1'b0;
    logic       Rot_A, Rot_B, Rot_C, Busy, Done;
    logic [7:0] Remaining;

    int errors = 0;
    int checks = 0;

    rotary_emulator #(.PHASE_CYC(PH), .GAP_CYC(GP), .CNT_W(8)) dut (
        .Fg_clk    (Fg_clk),
        .Reset     (Reset),
        .Cmd_valid (Cmd_valid),
        .Cmd_ready (Cmd_ready),
        .Cmd_dir   (Cmd_dir),
        .Cmd_count (Cmd_count),
        .Cmd_press (Cmd_press),
        .Rot_A     (Rot_A),
        .Rot_B     (Rot_B),
        .Rot_C     (Rot_C),
        .Busy      (Busy),
        .Done      (Done),
        .Remaining (Remaining)
    );

    always #5 Fg_clk = ~Fg_clk;

    // Advance one clock; sample 1 ns after the active edge.
    task automatic tick();
        @(posedge Fg_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Check every output in one cycle against expected values.
    task automatic chk_all(input int cyc, input logic a, input logic b, input logic c,
                           input logic busy, input logic done, input logic rdy,
                           input logic [7:0] rem);
        chk("rot_a", cyc, 32'(Rot_A), 32'(a));
        chk("rot_b", cyc, 32'(Rot_B), 32'(b));
        chk("rot_c", cyc, 32'(Rot_C), 32'(c));
        chk("busy", cyc, 32'(Busy), 32'(busy));
        chk("done", cyc, 32'(Done), 32'(done));
        chk("ready", cyc, 32'(Cmd_ready), 32'(rdy));
        chk("remaining", cyc, 32'(Remaining), 32'(rem));
    endtask

    // Issue an n-detent command at cycle 0 and check cycles 1..n*DET+1.
    // If poke > 0, a press command is pulsed while busy during that cycle;
    // it must be ignored.
    task automatic run_detents(input logic d, input int n, input int poke);
        logic ea, eb, prev_a, prev_b;
        logic [7:0] erem;
        int t, k;
        Cmd_valid = 1'b1; Cmd_dir = d; Cmd_count = 8'(n); Cmd_press = 1'b0;
        prev_a = 1'b1; prev_b = 1'b1;
        for (int c = 1; c <= n * DET + 1; c++) begin
            tick();
            Cmd_valid = 1'b0; Cmd_press = 1'b0;
            if (c <= n * DET) begin
                t = (c - 1) % DET;
                k = (c - 1) / DET;
                ea = 1'b1; eb = 1'b1;
                if (t < 4 * PH) begin
                    erem = 8'(n - k);
                    case (t / PH)
                        0: begin ea = 1'b1; eb = 1'b0; end
                        1: begin ea = 1'b0; eb = 1'b0; end
                        2: begin ea = 1'b0; eb = 1'b1; end
                        default: begin ea = 1'b1; eb = 1'b1; end
                    endcase
                    if (!d) begin
                        logic tmp;
                        tmp = ea; ea = eb; eb = tmp;
                    end
                end else begin
                    erem = 8'(n - k - 1);
                end
                chk_all(c, ea, eb, 1'b0, 1'b1, 1'b0, 1'b0, erem);
            end else begin
                chk_all(c, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
            end
            // Gray property: never both quadrature lines change together.
            chk("gray", c, 32'((Rot_A != prev_a) && (Rot_B != prev_b)), 32'd0);
            prev_a = Rot_A; prev_b = Rot_B;
            if (c == poke) begin
                Cmd_valid = 1'b1; Cmd_press = 1'b1; Cmd_count = 8'd7; Cmd_dir = ~d;
            end
        end
    endtask

    initial begin
        // 1. Reset held 3 cycles.
        Reset = 1'b1;
        tick(); tick(); tick();
        chk_all(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        Reset = 1'b0;
        tick();
        chk_all(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // 2. Increment, 3 detents (B falls c1, A falls c5, Done c73).
        run_detents(1'b1, 3, 0);
        tick();
        chk("done_clears", 74, 32'(Done), 32'd0);

        // 3. Decrement, 5 detents: A leads on every detent; a stray press
        //    pulsed while busy must be ignored.
        run_detents(1'b0, 5, 10);
        tick();

        // 4. Press: C high exactly in c1, Busy c1..c9, Done c10.
        Cmd_valid = 1'b1; Cmd_press = 1'b1; Cmd_count = 8'd9; Cmd_dir = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            Cmd_valid = 1'b0; Cmd_press = 1'b0;
            chk_all(c, 1'b1, 1'b1, (c == 1), (c <= 9), (c == 10), (c >= 10), 8'd0);
        end

        // 5. count=0: Done at c1, no edges, Busy stays low.
        Cmd_valid = 1'b1; Cmd_count = 8'd0; Cmd_dir = 1'b1;
        tick();
        Cmd_valid = 1'b0;
        chk_all(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        tick();
        chk_all(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // 6. Reset during PH1 of detent 2 (c29..c32 with these parameters).
        Cmd_valid = 1'b1; Cmd_count = 8'd3; Cmd_dir = 1'b1;
        tick();
        Cmd_valid = 1'b0;
        for (int c = 2; c <= 30; c++) tick();
        chk("ph1_det2_a", 30, 32'(Rot_A), 32'd0);
        chk("ph1_det2_b", 30, 32'(Rot_B), 32'd0);
        chk("ph1_det2_rem", 30, 32'(Remaining), 32'd2);
        Reset = 1'b1;
        tick();
        chk_all(31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        Reset = 1'b0;
        tick();
        chk_all(32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Accept again right after reset to confirm a clean restart.
        run_detents(1'b1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
